// File: rtl/snax_csr_buf_pkg.sv
// Shared types for the SNAX CSR request buffer: request record and error codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snax_csr_buf_pkg;

    localparam int unsigned CsrDataWidth = 32;
    localparam int unsigned CsrAddrWidth = 32;

    // Canonical request record carried through the request FIFO.
    typedef struct packed {
        logic [CsrDataWidth-1:0] data;
        logic [CsrAddrWidth-1:0] addr;
        logic                    write;
    } csr_req_t;

    // Sticky error codes; anything other than ERR_NONE raises err_o.
    typedef enum logic [1:0] {
        ERR_NONE            = 2'd0,
        ERR_UNSOLICITED_RSP = 2'd1
    } err_code_e;

    function automatic logic err_active(input err_code_e code);
        return code != ERR_NONE;
    endfunction

endpackage

// File: rtl/snax_csr_fifo.sv
// Generic valid/ready FIFO, no fall-through: a pushed entry appears on the head the next cycle.
// Latency: 1 cycle push-to-head.
// Backpressure: ready_o = !full, a push while full is refused even if a pop happens that cycle.
module snax_csr_fifo #(
    parameter int unsigned Depth = 2,
    parameter type         T     = logic,
    localparam int unsigned CntW = $clog2(Depth + 1),
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  T                data_i,
    input  logic            valid_i,
    output logic            ready_o,
    output T                data_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [CntW-1:0] usage_o
);

    T                mem_q [Depth];
    T                mem_d [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic push, pop;

    assign ready_o = (cnt_q != CntW'(Depth));
    assign valid_o = (cnt_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign usage_o = cnt_q;

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;

    // Next-state for storage, pointers (wrap at Depth) and occupancy.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            mem_d[wptr_q] = data_i;
            wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; storage clears so the head reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/snax_csr_req_buffer.sv
// In-order elastic CSR buffer between the SNAX translator and the streamer CSR port; optional perf counters under SNAX_CSR_BUF_PERF_EN.
// Latency: 1 cycle upstream-accept to dn_req_valid_o, 1 cycle dn response to up_rsp_valid_o.
// Backpressure: req FIFO full drops up_req_ready_o; reads stall (and block everything behind) when RspDepth reads are outstanding.
module snax_csr_req_buffer
    import snax_csr_buf_pkg::*;
#(
    parameter int unsigned DataWidth = CsrDataWidth,
    parameter int unsigned AddrWidth = CsrAddrWidth,
    parameter int unsigned ReqDepth  = 2,
    parameter int unsigned RspDepth  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] up_req_data_i,
    input  logic [AddrWidth-1:0] up_req_addr_i,
    input  logic                 up_req_write_i,
    input  logic                 up_req_valid_i,
    output logic                 up_req_ready_o,
    output logic [DataWidth-1:0] up_rsp_data_o,
    output logic                 up_rsp_valid_o,
    input  logic                 up_rsp_ready_i,
    output logic [DataWidth-1:0] dn_req_data_o,
    output logic [AddrWidth-1:0] dn_req_addr_o,
    output logic                 dn_req_write_o,
    output logic                 dn_req_valid_o,
    input  logic                 dn_req_ready_i,
    input  logic [DataWidth-1:0] dn_rsp_data_i,
    input  logic                 dn_rsp_valid_i,
    output logic                 dn_rsp_ready_o,
    output logic                 idle_o,
    output logic                 err_o
`ifdef SNAX_CSR_BUF_PERF_EN
    ,
    output logic [31:0]          stall_cnt_o,
    output logic [31:0]          rd_cnt_o
`endif
);

    localparam int unsigned ReqCntW = $clog2(ReqDepth + 1);
    localparam int unsigned OutW    = $clog2(RspDepth + 1);

    // Same shape as csr_req_t, but sized by this instance's widths.
    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [AddrWidth-1:0] addr;
        logic                 write;
    } req_t;

    typedef logic [DataWidth-1:0] rsp_t;

    req_t             req_in, req_head;
    logic             req_vld, req_pop_rdy;
    logic [ReqCntW-1:0] req_usage;
    logic             credit_ok;

    logic             rsp_push_vld;
    logic [OutW-1:0]  rsp_usage;

    logic [OutW-1:0]  outstanding_q, outstanding_d;
    err_code_e        err_code_q, err_code_d;

    logic             rd_issue, rsp_pop, unsolicited;

    assign req_in = '{data: up_req_data_i, addr: up_req_addr_i, write: up_req_write_i};

    snax_csr_fifo #(
        .Depth (ReqDepth),
        .T     (req_t)
    ) i_req_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .data_i  (req_in),
        .valid_i (up_req_valid_i),
        .ready_o (up_req_ready_o),
        .data_o  (req_head),
        .valid_o (req_vld),
        .ready_i (req_pop_rdy),
        .usage_o (req_usage)
    );

    // Writes always pass; a read needs a free response slot. The head is
    // never bypassed, so a stalled read holds back every write behind it.
    assign credit_ok      = req_head.write || (outstanding_q < OutW'(RspDepth));
    assign dn_req_valid_o = req_vld && credit_ok;
    assign req_pop_rdy    = dn_req_ready_i && credit_ok;
    assign dn_req_data_o  = req_head.data;
    assign dn_req_addr_o  = req_head.addr;
    assign dn_req_write_o = req_head.write;

    // A response with no read waiting for it (every outstanding read already
    // has its data buffered) is unsolicited and is dropped.
    assign unsolicited  = dn_rsp_valid_i && dn_rsp_ready_o && (outstanding_q == rsp_usage);
    assign rsp_push_vld = dn_rsp_valid_i && (outstanding_q != rsp_usage);

    snax_csr_fifo #(
        .Depth (RspDepth),
        .T     (rsp_t)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .data_i  (dn_rsp_data_i),
        .valid_i (rsp_push_vld),
        .ready_o (dn_rsp_ready_o),
        .data_o  (up_rsp_data_o),
        .valid_o (up_rsp_valid_o),
        .ready_i (up_rsp_ready_i),
        .usage_o (rsp_usage)
    );

    assign rd_issue = dn_req_valid_o && dn_req_ready_i && !req_head.write;
    assign rsp_pop  = up_rsp_valid_o && up_rsp_ready_i;

    // Credit accounting and sticky error capture.
    always_comb begin
        outstanding_d = outstanding_q;
        case ({rd_issue, rsp_pop})
            2'b10:   outstanding_d = outstanding_q + OutW'(1);
            2'b01:   outstanding_d = outstanding_q - OutW'(1);
            default: outstanding_d = outstanding_q;
        endcase
        err_code_d = err_code_q;
        if (unsolicited) err_code_d = ERR_UNSOLICITED_RSP;
    end

    // Credit counter and error code registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            err_code_q    <= ERR_NONE;
        end else begin
            outstanding_q <= outstanding_d;
            err_code_q    <= err_code_d;
        end
    end

    assign err_o  = err_active(err_code_q);
    assign idle_o = (req_usage == '0) && (outstanding_q == '0);

`ifdef SNAX_CSR_BUF_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;

    // Saturating counters: downstream stall cycles and completed reads.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        if (dn_req_valid_o && !dn_req_ready_i && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (rsp_pop && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 32'd1;
    end

    // Perf counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            rd_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign rd_cnt_o    = rd_cnt_q;
`endif

endmodule

// File: tb/tb_snax_csr_req_buffer.sv
// Self-checking bench for snax_csr_req_buffer (default parameters ReqDepth=2, RspDepth=2).
// Latency: inputs driven on the falling edge, state-derived outputs checked before the next rising edge.
// Backpressure: exercised by the vector table (req full, credit stall, rsp full).
module tb_snax_csr_req_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] up_req_data_i = '0;
    logic [31:0] up_req_addr_i = '0;
    logic        up_req_write_i = 1'b0;
    logic        up_req_valid_i = 1'b0;
    logic        up_req_ready_o;
    logic [31:0] up_rsp_data_o;
    logic        up_rsp_valid_o;
    logic        up_rsp_ready_i = 1'b0;
    logic [31:0] dn_req_data_o;
    logic [31:0] dn_req_addr_o;
    logic        dn_req_write_o;
    logic        dn_req_valid_o;
    logic        dn_req_ready_i = 1'b0;
    logic [31:0] dn_rsp_data_i = '0;
    logic        dn_rsp_valid_i = 1'b0;
    logic        dn_rsp_ready_o;
    logic        idle_o;
    logic        err_o;
`ifdef SNAX_CSR_BUF_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] rd_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    snax_csr_req_buffer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .up_req_data_i  (up_req_data_i),
        .up_req_addr_i  (up_req_addr_i),
        .up_req_write_i (up_req_write_i),
        .up_req_valid_i (up_req_valid_i),
        .up_req_ready_o (up_req_ready_o),
        .up_rsp_data_o  (up_rsp_data_o),
        .up_rsp_valid_o (up_rsp_valid_o),
        .up_rsp_ready_i (up_rsp_ready_i),
        .dn_req_data_o  (dn_req_data_o),
        .dn_req_addr_o  (dn_req_addr_o),
        .dn_req_write_o (dn_req_write_o),
        .dn_req_valid_o (dn_req_valid_o),
        .dn_req_ready_i (dn_req_ready_i),
        .dn_rsp_data_i  (dn_rsp_data_i),
        .dn_rsp_valid_i (dn_rsp_valid_i),
        .dn_rsp_ready_o (dn_rsp_ready_o),
        .idle_o         (idle_o),
        .err_o          (err_o)
`ifdef SNAX_CSR_BUF_PERF_EN
        ,
        .stall_cnt_o    (stall_cnt_o),
        .rd_cnt_o       (rd_cnt_o)
`endif
    );

    typedef struct {
        // inputs applied this cycle
        logic        uv, uw;
        logic [31:0] ua, ud;
        logic        dr, rv;
        logic [31:0] rd;
        logic        ur;
        // outputs expected this cycle, before the rising edge
        logic        e_rdy, e_dv;
        logic [31:0] e_da, e_dd;
        logic        e_dw, e_rsv;
        logic [31:0] e_rsd;
        logic        e_rr, e_idle, e_err;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t v(
        input logic uv, input logic uw, input logic [31:0] ua, input logic [31:0] ud,
        input logic dr, input logic rv, input logic [31:0] rd, input logic ur,
        input logic e_rdy, input logic e_dv, input logic [31:0] e_da, input logic [31:0] e_dd,
        input logic e_dw, input logic e_rsv, input logic [31:0] e_rsd,
        input logic e_rr, input logic e_idle, input logic e_err);
        vec_t r;
        r.uv = uv; r.uw = uw; r.ua = ua; r.ud = ud; r.dr = dr; r.rv = rv; r.rd = rd; r.ur = ur;
        r.e_rdy = e_rdy; r.e_dv = e_dv; r.e_da = e_da; r.e_dd = e_dd; r.e_dw = e_dw;
        r.e_rsv = e_rsv; r.e_rsd = e_rsd; r.e_rr = e_rr; r.e_idle = e_idle; r.e_err = e_err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic uv, input logic uw, input logic [31:0] ua, input logic [31:0] ud,
                         input logic dr, input logic rv, input logic [31:0] rd, input logic ur);
        up_req_valid_i = uv; up_req_write_i = uw; up_req_addr_i = ua; up_req_data_i = ud;
        dn_req_ready_i = dr; dn_rsp_valid_i = rv; dn_rsp_data_i = rd; up_rsp_ready_i = ur;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " up_req_ready"}, 32'(up_req_ready_o), 32'd1);
        chk({tag, " dn_req_valid"}, 32'(dn_req_valid_o), 32'd0);
        chk({tag, " up_rsp_valid"}, 32'(up_rsp_valid_o), 32'd0);
        chk({tag, " dn_rsp_ready"}, 32'(dn_rsp_ready_o), 32'd1);
        chk({tag, " idle"},         32'(idle_o),         32'd1);
        chk({tag, " err"},          32'(err_o),          32'd0);
        chk({tag, " dn_req_addr"},  dn_req_addr_o,       32'd0);
        chk({tag, " dn_req_data"},  dn_req_data_o,       32'd0);
        chk({tag, " dn_req_write"}, 32'(dn_req_write_o), 32'd0);
        chk({tag, " up_rsp_data"},  up_rsp_data_o,       32'd0);
    endtask

    initial begin
        //            uv uw ua      ud      dr rv rd     ur | rdy dv da      dd      dw rsv rsd    rr idl err
        // write burst, downstream stalled for 5 cycles
        vecs.push_back(v(1, 1, 'h3C0, 'hA5, 0, 0, 0,    0,   1, 0, 0,     0,     0, 0, 0,    1, 1, 0));
        vecs.push_back(v(1, 1, 'h3C1, 'hB6, 0, 0, 0,    0,   1, 1, 'h3C0, 'hA5,  1, 0, 0,    1, 0, 0));
        vecs.push_back(v(1, 1, 'h3C2, 'hC7, 0, 0, 0,    0,   0, 1, 'h3C0, 'hA5,  1, 0, 0,    1, 0, 0));
        vecs.push_back(v(1, 1, 'h3C2, 'hC7, 0, 0, 0,    0,   0, 1, 'h3C0, 'hA5,  1, 0, 0,    1, 0, 0));
        vecs.push_back(v(1, 1, 'h3C2, 'hC7, 0, 0, 0,    0,   0, 1, 'h3C0, 'hA5,  1, 0, 0,    1, 0, 0));
        vecs.push_back(v(1, 1, 'h3C2, 'hC7, 1, 0, 0,    0,   0, 1, 'h3C0, 'hA5,  1, 0, 0,    1, 0, 0));
        vecs.push_back(v(1, 1, 'h3C2, 'hC7, 1, 0, 0,    0,   1, 1, 'h3C1, 'hB6,  1, 0, 0,    1, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 0, 0,    0,   1, 1, 'h3C2, 'hC7,  1, 0, 0,    1, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 0, 0,    0,   1, 0, 0,     0,     0, 0, 0,    1, 1, 0));
        // three reads against two credits, responses held then released
        vecs.push_back(v(1, 0, 'h10,  0,    1, 0, 0,    0,   1, 0, 0,     0,     0, 0, 0,    1, 1, 0));
        vecs.push_back(v(1, 0, 'h14,  0,    1, 0, 0,    0,   1, 1, 'h10,  0,     0, 0, 0,    1, 0, 0));
        vecs.push_back(v(1, 0, 'h18,  0,    1, 0, 0,    0,   1, 1, 'h14,  0,     0, 0, 0,    1, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 1, 'h11, 0,   1, 0, 0,     0,     0, 0, 0,    1, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 1, 'h22, 0,   1, 0, 0,     0,     0, 1, 'h11, 1, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 0, 0,    0,   1, 0, 0,     0,     0, 1, 'h11, 0, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 0, 0,    0,   1, 0, 0,     0,     0, 1, 'h11, 0, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 0, 0,    1,   1, 0, 0,     0,     0, 1, 'h11, 0, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 0, 0,    0,   1, 1, 'h18,  0,     0, 1, 'h22, 1, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 1, 'h33, 1,   1, 0, 0,     0,     0, 1, 'h22, 1, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 0, 0,    1,   1, 0, 0,     0,     0, 1, 'h33, 1, 0, 0));
        // ordering: credits exhausted, a queued read holds back a write
        vecs.push_back(v(1, 0, 'h20,  0,    1, 0, 0,    0,   1, 0, 0,     0,     0, 0, 0,    1, 1, 0));
        vecs.push_back(v(1, 0, 'h24,  0,    1, 0, 0,    0,   1, 1, 'h20,  0,     0, 0, 0,    1, 0, 0));
        vecs.push_back(v(1, 0, 'h28,  0,    1, 0, 0,    0,   1, 1, 'h24,  0,     0, 0, 0,    1, 0, 0));
        vecs.push_back(v(1, 1, 'h30,  'h5A, 1, 0, 0,    0,   1, 0, 0,     0,     0, 0, 0,    1, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 1, 'h44, 0,   0, 0, 0,     0,     0, 0, 0,    1, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 1, 'h55, 0,   0, 0, 0,     0,     0, 1, 'h44, 1, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 0, 0,    1,   0, 0, 0,     0,     0, 1, 'h44, 0, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 0, 0,    0,   0, 1, 'h28,  0,     0, 1, 'h55, 1, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 0, 0,    0,   1, 1, 'h30,  'h5A,  1, 1, 'h55, 1, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 1, 'h66, 1,   1, 0, 0,     0,     0, 1, 'h55, 1, 0, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 0, 0,    1,   1, 0, 0,     0,     0, 1, 'h66, 1, 0, 0));
        // unsolicited response while nothing is outstanding
        vecs.push_back(v(0, 0, 0,     0,    1, 1, 'h77, 0,   1, 0, 0,     0,     0, 0, 0,    1, 1, 0));
        vecs.push_back(v(0, 0, 0,     0,    1, 0, 0,    0,   1, 0, 0,     0,     0, 0, 0,    1, 1, 1));
        vecs.push_back(v(0, 0, 0,     0,    1, 0, 0,    1,   1, 0, 0,     0,     0, 0, 0,    1, 1, 1));

        // reset values while held in reset
        #12;
        chk_reset_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk_i);
            drive(vecs[i].uv, vecs[i].uw, vecs[i].ua, vecs[i].ud,
                  vecs[i].dr, vecs[i].rv, vecs[i].rd, vecs[i].ur);
            #1;
            chk($sformatf("v%0d up_req_ready", i), 32'(up_req_ready_o), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d dn_req_valid", i), 32'(dn_req_valid_o), 32'(vecs[i].e_dv));
            if (vecs[i].e_dv) begin
                chk($sformatf("v%0d dn_req_addr", i),  dn_req_addr_o,       vecs[i].e_da);
                chk($sformatf("v%0d dn_req_data", i),  dn_req_data_o,       vecs[i].e_dd);
                chk($sformatf("v%0d dn_req_write", i), 32'(dn_req_write_o), 32'(vecs[i].e_dw));
            end
            chk($sformatf("v%0d up_rsp_valid", i), 32'(up_rsp_valid_o), 32'(vecs[i].e_rsv));
            if (vecs[i].e_rsv) chk($sformatf("v%0d up_rsp_data", i), up_rsp_data_o, vecs[i].e_rsd);
            chk($sformatf("v%0d dn_rsp_ready", i), 32'(dn_rsp_ready_o), 32'(vecs[i].e_rr));
            chk($sformatf("v%0d idle", i), 32'(idle_o), 32'(vecs[i].e_idle));
            chk($sformatf("v%0d err", i),  32'(err_o),  32'(vecs[i].e_err));
        end

        // reset mid-operation: two writes queued behind a stalled downstream
        @(negedge clk_i);
        drive(1, 1, 32'h100, 32'h1, 0, 0, 0, 0);
        @(negedge clk_i);
        drive(1, 1, 32'h104, 32'h2, 0, 0, 0, 0);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("midrst queued dn_req_valid", 32'(dn_req_valid_o), 32'd1);
        chk("midrst queued up_req_ready", 32'(up_req_ready_o), 32'd0);
        chk("midrst queued dn_req_addr",  dn_req_addr_o,       32'h100);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            #1;
            chk($sformatf("post-rst%0d dn_req_valid", k), 32'(dn_req_valid_o), 32'd0);
            chk($sformatf("post-rst%0d up_rsp_valid", k), 32'(up_rsp_valid_o), 32'd0);
            chk($sformatf("post-rst%0d idle", k),         32'(idle_o),         32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
